// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads to instruction memory and
// presents one instruction at a time to decode. Redirects flush any fetch in
// flight, and a read that is already issued is drained and its data dropped.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus_four,
  output logic [31:0] out_instruction,
  output logic        inst_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READY = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ppf_q, ppf_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pc_inc;

  // Redirect target is forced to a word boundary; increment wraps mod 2^32.
  assign target = redirect_pc & ~XLEN'(3);
  assign pc_inc = pc_q + XLEN'(4);

  // Request is live in FETCH and DROP, but never while reset is being sampled.
  assign imem_req        = !reset && (state_q != S_READY);
  assign imem_addr       = addr_q;
  assign pc_plus_four    = ppf_q;
  assign out_instruction = instr_q;
  assign inst_valid      = valid_q;

  // Next-state and datapath updates; redirect outranks hold and ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ppf_d   = ppf_q;
    valid_d = valid_q;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (imem_ack) begin
            addr_d = target;
          end else begin
            // Read stays on the bus at the old address until it completes.
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          state_d = S_READY;
          instr_d = imem_rdata;
          ppf_d   = pc_inc;
          valid_d = 1'b1;
        end
      end
      S_READY: begin
        if (redirect) begin
          state_d = S_FETCH;
          pc_d    = target;
          addr_d  = target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!hold) begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
          addr_d  = pc_inc;
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          // Stale data is discarded; restart at the most recent pc.
          state_d = S_FETCH;
          addr_d  = redirect ? target : pc_q;
        end
      end
      default: begin
        state_d = S_FETCH;
        addr_d  = pc_q;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ppf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ppf_q   <= ppf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model of the fetch protocol and a variable-latency memory.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, hold, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_plus_four, out_instruction;
  logic        inst_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;
  int wcnt  = 0;

  // Behavioural model: next fetch pc, address on the bus, whether a read is
  // outstanding, whether that read is stale, and the presented instruction.
  bit          m_busy, m_stale, m_valid;
  logic [31:0] m_pc, m_addr, m_instr, m_ppf;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .hold(hold), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_plus_four(pc_plus_four),
    .out_instruction(out_instruction), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  // Distinct word per address (odd multiplier is a bijection mod 2^32).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Apply inputs just after the falling edge, then let the memory answer.
  task automatic drive(input logic r, input logic h, input logic rd,
                       input logic [31:0] tgt, input bit spurious);
    reset = r; hold = h; redirect = rd; redirect_pc = tgt;
    #1;
    imem_ack   = imem_req ? (wcnt >= lat) : spurious;
    imem_rdata = (imem_req && imem_ack) ? mem_word(imem_addr) : $urandom();
  endtask

  // Advance model and memory across one rising edge, return at the falling edge.
  task automatic tick();
    logic [31:0] t;
    t = redirect_pc & ~32'd3;
    if (reset) begin
      m_pc = RESET_PC; m_addr = RESET_PC; m_valid = 0; m_instr = '0;
      m_ppf = '0; m_stale = 0; m_busy = 1;
    end else if (redirect) begin
      if (m_busy && !imem_ack) m_stale = 1;
      else begin m_stale = 0; m_addr = t; end
      m_busy = 1; m_valid = 0; m_instr = '0; m_pc = t;
    end else if (m_busy) begin
      if (imem_ack) begin
        if (m_stale) begin m_stale = 0; m_addr = m_pc; end
        else begin
          m_valid = 1; m_instr = imem_rdata; m_ppf = m_pc + 32'd4; m_busy = 0;
        end
      end
    end else if (!hold) begin
      m_pc = m_pc + 32'd4; m_addr = m_pc; m_busy = 1; m_valid = 0; m_instr = '0;
    end
    if (reset || !imem_req || imem_ack) wcnt = 0;
    else wcnt = wcnt + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    lat = 0;
    drive(1, 0, 0, '0, 0);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    tick();
    drive(1, 1, 1, 32'h44, 1);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req2 got=%0b exp=0", imem_req); end
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
    n_cmp++; if (out_instruction !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h exp=0", out_instruction); end
    n_cmp++; if (pc_plus_four !== 32'h0) begin n_bad++; $display("FAIL reset_ppf got=%h exp=0", pc_plus_four); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_first_req got=%0b exp=1", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_first_addr got=%h exp=%h", imem_addr, RESET_PC); end
    tick();
  endtask

  task automatic test_stream();
    lat = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_bad++; $display("FAIL stream_req k=%0d got=%0b/%h exp=1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
      tick();
      drive(0, 0, 0, '0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || pc_plus_four !== 32'(4 * k + 4)) begin
        n_bad++; $display("FAIL stream_ppf k=%0d got=%0b/%h exp=1/%h", k, inst_valid, pc_plus_four, 32'(4 * k + 4)); end
      n_cmp++; if (out_instruction !== mem_word(32'(4 * k))) begin
        n_bad++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, out_instruction, mem_word(32'(4 * k))); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stream_noreq k=%0d got=%0b exp=0", k, imem_req); end
      tick();
      drive(0, 0, 0, '0, 0);
    end
  endtask

  task automatic test_hold();
    lat = 0;
    do_reset();
    drive(0, 0, 1, 32'h10, 0);
    tick();
    drive(0, 0, 0, '0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, '0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || pc_plus_four !== 32'h14 || out_instruction !== mem_word(32'h10)) begin
        n_bad++; $display("FAIL hold_stable k=%0d got=%0b/%h/%h exp=1/14/%h", k, inst_valid, pc_plus_four, out_instruction, mem_word(32'h10)); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_noreq k=%0d got=%0b exp=0", k, imem_req); end
      tick();
    end
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL hold_release got=%0b exp=1", inst_valid); end
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      n_bad++; $display("FAIL hold_next got=%0b/%h exp=1/14", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_redirect_drop();
    int waited;
    lat = 0;
    do_reset();
    drive(0, 0, 1, 32'h20, 0);
    tick();
    lat = 3;
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_bad++; $display("FAIL drop_issue got=%0b/%h exp=1/20", imem_req, imem_addr); end
    tick();
    drive(0, 0, 1, 32'h103, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, '0, 0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL drop_keep k=%0d got=%0b/%h/%0b exp=1/20/0", k, imem_req, imem_addr, inst_valid); end
      tick();
    end
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL drop_refetch got=%0b/%0b/%h exp=0/1/100", inst_valid, imem_req, imem_addr); end
    waited = 0;
    while (!inst_valid && waited < 8) begin tick(); drive(0, 0, 0, '0, 0); waited++; end
    n_cmp++; if (waited !== 4) begin n_bad++; $display("FAIL drop_latency got=%0d exp=4", waited); end
    n_cmp++; if (pc_plus_four !== 32'h104 || out_instruction !== mem_word(32'h100)) begin
      n_bad++; $display("FAIL drop_data got=%h/%h exp=104/%h", pc_plus_four, out_instruction, mem_word(32'h100)); end
    tick();
  endtask

  task automatic test_redirect_hold();
    lat = 0;
    do_reset();
    tick();
    drive(0, 1, 1, 32'h40, 0);
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (inst_valid !== 1'b0 || out_instruction !== 32'h0) begin
      n_bad++; $display("FAIL rdhold_clear got=%0b/%h exp=0/0", inst_valid, out_instruction); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_bad++; $display("FAIL rdhold_fetch got=%0b/%h exp=1/40", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_wrap();
    lat = 0;
    do_reset();
    drive(0, 0, 1, 32'hFFFF_FFFF, 0);
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (inst_valid !== 1'b1 || pc_plus_four !== 32'h0 || out_instruction !== mem_word(32'hFFFF_FFFC)) begin
      n_bad++; $display("FAIL wrap_ppf got=%0b/%h/%h exp=1/0/%h", inst_valid, pc_plus_four, out_instruction, mem_word(32'hFFFF_FFFC)); end
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL wrap_next got=%0b/%h exp=1/0", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_reset_in_drop();
    int waited;
    lat = 3;
    do_reset();
    drive(0, 0, 1, 32'h80, 0);
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL rdrop_stale got=%0b/%h exp=1/%h", imem_req, imem_addr, RESET_PC); end
    tick();
    drive(1, 0, 0, '0, 0);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rdrop_req got=%0b exp=0", imem_req); end
    tick();
    drive(0, 0, 0, '0, 0);
    n_cmp++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL rdrop_restart got=%0b/%0b/%h exp=0/1/%h", inst_valid, imem_req, imem_addr, RESET_PC); end
    waited = 0;
    while (!inst_valid && waited < 8) begin tick(); drive(0, 0, 0, '0, 0); waited++; end
    n_cmp++; if (inst_valid !== 1'b1 || pc_plus_four !== RESET_PC + 32'd4 || out_instruction !== mem_word(RESET_PC)) begin
      n_bad++; $display("FAIL rdrop_fetch got=%0b/%h/%h exp=1/%h/%h", inst_valid, pc_plus_four, out_instruction, RESET_PC + 32'd4, mem_word(RESET_PC)); end
    tick();
  endtask

  task automatic test_random();
    bit r, h, rd, sp;
    lat = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      h  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 14) == 0);
      if (wcnt == 0 && $urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
      drive(r, h, rd, $urandom(), sp);
      n_cmp++; if (imem_req !== (!reset && m_busy)) begin
        n_bad++; $display("FAIL rnd_req i=%0d got=%0b exp=%0b", i, imem_req, !reset && m_busy); end
      if (!reset && m_busy) begin
        n_cmp++; if (imem_addr !== m_addr) begin n_bad++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, imem_addr, m_addr); end
      end
      n_cmp++; if (inst_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, inst_valid, m_valid); end
      n_cmp++; if (out_instruction !== m_instr) begin n_bad++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, out_instruction, m_instr); end
      n_cmp++; if (pc_plus_four !== m_ppf) begin n_bad++; $display("FAIL rnd_ppf i=%0d got=%h exp=%h", i, pc_plus_four, m_ppf); end
      if (inst_valid === 1'b1) begin
        n_cmp++; if (out_instruction !== mem_word(pc_plus_four - 32'd4)) begin
          n_bad++; $display("FAIL rnd_word i=%0d got=%h exp=%h", i, out_instruction, mem_word(pc_plus_four - 32'd4)); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    test_reset();
    test_stream();
    test_hold();
    test_redirect_drop();
    test_redirect_hold();
    test_wrap();
    test_reset_in_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
